// File: rtl/enable_tick_gen.sv
// Programmable clock-enable generator: base tick every D cycles, sub tick every SUB_DIV base ticks.
// The divisor can be reloaded at run time; a new value takes effect only at a wrap or a clear.
module enable_tick_gen #(
  parameter int CNT_WIDTH   = 26,
  parameter int DEFAULT_DIV = 50_000_000,
  parameter int SUB_DIV     = 60
) (
  input  logic                 tick_clock,
  input  logic                 tick_reset,
  input  logic                 tick_run,
  input  logic                 tick_clear,
  input  logic [CNT_WIDTH-1:0] tick_div_value,
  input  logic                 tick_div_load,
  output logic                 tick_div_pending,
  output logic [CNT_WIDTH-1:0] tick_div_active,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic                 tick_pulseout,
  output logic                 tick_sub_pulseout
);

  localparam int SUB_WIDTH = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [SUB_WIDTH-1:0] SUB_LAST = SUB_WIDTH'(SUB_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] DEF_DIV  = (DEFAULT_DIV < 1) ? CNT_WIDTH'(1) : CNT_WIDTH'(DEFAULT_DIV);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [SUB_WIDTH-1:0] sub_q, sub_d;
  logic [CNT_WIDTH-1:0] active_q, active_d;
  logic [CNT_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;

  logic [CNT_WIDTH-1:0] div_eff;
  logic [CNT_WIDTH-1:0] div_last;
  logic [CNT_WIDTH-1:0] load_val;
  logic                 terminal;
  logic                 pulse;
  logic                 sub_pulse;
  logic                 apply;

  always_comb begin
    div_eff    = (active_q == '0) ? CNT_WIDTH'(1) : active_q;
    div_last   = div_eff - CNT_WIDTH'(1);
    // >= rather than == so an out-of-range count still wraps instead of running away
    terminal   = (count_q >= div_last);
    pulse      = tick_reset & tick_run & ~tick_clear & terminal;
    sub_pulse  = pulse & (sub_q >= SUB_LAST);
    apply      = pulse | tick_clear;
    load_val   = (tick_div_value == '0) ? CNT_WIDTH'(1) : tick_div_value;

    count_d    = count_q;
    sub_d      = sub_q;
    active_d   = active_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;

    if (tick_clear) begin
      count_d = '0;
      sub_d   = '0;
    end else if (tick_run) begin
      if (terminal) begin
        count_d = '0;
        sub_d   = (sub_q >= SUB_LAST) ? '0 : sub_q + SUB_WIDTH'(1);
      end else begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end

    // A load coinciding with the switch point bypasses the pending slot entirely
    if (apply) begin
      if (tick_div_load) begin
        active_d = load_val;
      end else if (pend_q) begin
        active_d = pend_val_q;
      end
      pend_d = 1'b0;
    end else if (tick_div_load) begin
      pend_val_d = load_val;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge tick_clock or negedge tick_reset) begin
    if (!tick_reset) begin
      count_q    <= '0;
      sub_q      <= '0;
      active_q   <= DEF_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      sub_q      <= sub_d;
      active_q   <= active_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
    end
  end

  assign tick_count        = count_q;
  assign tick_div_active   = active_q;
  assign tick_div_pending  = pend_q;
  assign tick_pulseout     = pulse;
  assign tick_sub_pulseout = sub_pulse;

endmodule

// File: tb/tb_enable_tick_gen.sv
// Bench for enable_tick_gen: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural model of period / pulse-count arithmetic.
module tb_enable_tick_gen;

  localparam int CW  = 4;
  localparam int DEF = 5;
  localparam int SUB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          clr = 1'b0;
  logic          load = 1'b0;
  logic [CW-1:0] val = '0;
  logic          pending;
  logic [CW-1:0] active;
  logic [CW-1:0] count;
  logic          pulse;
  logic          sub_pulse;

  int vectors = 0;
  int miscompares = 0;

  enable_tick_gen #(.CNT_WIDTH(CW), .DEFAULT_DIV(DEF), .SUB_DIV(SUB)) dut (
    .tick_clock       (clk),
    .tick_reset       (rst_n),
    .tick_run         (run),
    .tick_clear       (clr),
    .tick_div_value   (val),
    .tick_div_load    (load),
    .tick_div_pending (pending),
    .tick_div_active  (active),
    .tick_count       (count),
    .tick_pulseout    (pulse),
    .tick_sub_pulseout(sub_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the current period, total base ticks since clear/reset,
  // divisor in use and the requested-but-not-yet-applied divisor.
  int m_pos = 0;
  int m_ticks = 0;
  int m_div = DEF;
  bit m_has_req = 0;
  int m_req = 0;

  function automatic int eff_div();
    return (m_div < 1) ? 1 : m_div;
  endfunction

  function automatic bit exp_pulse();
    return rst_n && run && !clr && (m_pos == eff_div() - 1);
  endfunction

  function automatic bit exp_sub();
    return exp_pulse() && ((m_ticks % SUB) == SUB - 1);
  endfunction

  int  mv_new;
  bit  mv_tick;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_ticks = 0; m_div = DEF; m_has_req = 0; m_req = 0;
    end else begin
      mv_tick = exp_pulse();
      mv_new  = (int'(val) == 0) ? 1 : int'(val);
      if (clr) begin
        m_pos = 0; m_ticks = 0;
      end else if (run) begin
        m_pos = (m_pos + 1) % eff_div();
        if (mv_tick) m_ticks = m_ticks + 1;
      end
      if (mv_tick || clr) begin
        if (load) m_div = mv_new;
        else if (m_has_req) m_div = m_req;
        m_has_req = 0;
      end else if (load) begin
        m_req = mv_new; m_has_req = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("count",   int'(count),     m_pos);
    chk("active",  int'(active),    m_div);
    chk("pending", int'(pending),   int'(m_has_req));
    chk("pulse",   int'(pulse),     int'(exp_pulse()));
    chk("sub",     int'(sub_pulse), int'(exp_sub()));
  end

  task automatic drive_now(input bit r, input bit c, input bit l, input int v);
    run = r; clr = c; load = l; val = CW'(v);
    #1;
  endtask

  task automatic step(input bit r, input bit c, input bit l, input int v);
    @(posedge clk);
    #2;
    drive_now(r, c, l, v);
  endtask

  task automatic wait_cnt(input int t);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, 0);
      if (int'(count) == t) found = 1;
    end
    if (!found) chk("wait_cnt_timeout", int'(count), t);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_count"},   int'(count),     0);
    chk({tag, "_active"},  int'(active),    DEF);
    chk({tag, "_pending"}, int'(pending),   0);
    chk({tag, "_pulse"},   int'(pulse),     0);
    chk({tag, "_sub"},     int'(sub_pulse), 0);
  endtask

  initial begin
    // 1: reset held with run requested, then free running
    run = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset_checks("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("d1_count0", int'(count), 0);
    chk("d1_pulse0", int'(pulse), 0);
    for (int k = 1; k < 15; k++) begin
      step(1, 0, 0, 0);
      chk("d1_count", int'(count), k % 5);
      chk("d1_pulse", int'(pulse), int'(k % 5 == 4));
      chk("d1_sub",   int'(sub_pulse), int'(k == 14));
    end

    // 2: pause at count 2 for 7 cycles, then resume
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 0);
      chk("d2_hold", int'(count), 2);
      chk("d2_nopulse", int'(pulse), 0);
    end
    step(1, 0, 0, 0);
    chk("d2_r1", int'(pulse), 0);
    step(1, 0, 0, 0);
    chk("d2_r2_count", int'(count), 3);
    step(1, 0, 0, 0);
    chk("d2_r3_count", int'(count), 4);
    chk("d2_r3_pulse", int'(pulse), 1);

    // 3: load 3 mid-period
    wait_cnt(1);
    drive_now(1, 0, 1, 3);
    step(1, 0, 0, 0);
    chk("d3_pending", int'(pending), 1);
    chk("d3_active_old", int'(active), 5);
    wait_cnt(0);
    chk("d3_active_new", int'(active), 3);
    chk("d3_pending_clr", int'(pending), 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("d3_pulse_at2", int'(pulse), 1);

    // 4: load 0 becomes divisor 1
    wait_cnt(1);
    drive_now(1, 0, 1, 0);
    wait_cnt(0);
    chk("d4_active", int'(active), 1);
    step(1, 0, 0, 0);
    chk("d4_pulse", int'(pulse), 1);
    chk("d4_count", int'(count), 0);

    // 5: loads at the wrap apply directly; last pending write wins
    drive_now(1, 0, 1, 4);
    step(1, 0, 0, 0);
    chk("d5_direct_active", int'(active), 4);
    chk("d5_direct_pending", int'(pending), 0);
    wait_cnt(1);
    drive_now(1, 0, 1, 7);
    step(1, 0, 1, 2);
    step(1, 0, 0, 0);
    chk("d5_pending", int'(pending), 1);
    wait_cnt(0);
    chk("d5_last_wins", int'(active), 2);
    wait_cnt(1);
    drive_now(1, 0, 1, 5);
    step(1, 0, 0, 0);
    chk("d5_onpulse_pending", int'(pending), 0);
    chk("d5_onpulse_active", int'(active), 5);

    // 6: clear applies the pending divisor; async reset discards a pending one
    wait_cnt(1);
    drive_now(1, 0, 1, 3);
    wait_cnt(3);
    chk("d6_pending", int'(pending), 1);
    drive_now(1, 1, 0, 0);
    chk("d6_clr_pulse", int'(pulse), 0);
    step(1, 0, 0, 0);
    chk("d6_clr_count", int'(count), 0);
    chk("d6_clr_active", int'(active), 3);
    chk("d6_clr_pending", int'(pending), 0);
    wait_cnt(0);
    drive_now(1, 0, 1, 2);
    step(1, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    reset_checks("arst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 199) == 0) begin
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
    end
    step(0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
